// File: rtl/vga_text_if.sv
// Bundle between the text core and the board side: the character and font
// RAM ports, the cursor controls and the VGA DAC pins.
interface vga_text_if;
  logic [11:0] char_addr;
  logic [15:0] char_data;
  logic [11:0] font_addr;
  logic [7:0]  font_data;
  logic        cursor_en;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        hs;
  logic        vs;
  logic [4:0]  r;
  logic [5:0]  g;
  logic [4:0]  b;
  logic        frame_start;

  // Core side: drives addresses and video, reads memory data and cursor.
  modport master (
    output char_addr, font_addr, hs, vs, r, g, b, frame_start,
    input  char_data, font_data, cursor_en, cursor_col, cursor_row
  );

  // Board side: RAMs, cursor source and the VGA connector.
  modport slave (
    input  char_addr, font_addr, hs, vs, r, g, b, frame_start,
    output char_data, font_data, cursor_en, cursor_col, cursor_row
  );
endinterface

// File: rtl/vga_text_core.sv
// VGA text-mode core: timing counters, 3-stage character/font pipeline,
// 16-colour palette with blink and hardware cursor.
module vga_text_core #(
  parameter int H_VISIBLE    = 640,
  parameter int H_FRONT      = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BACK       = 48,
  parameter int V_VISIBLE    = 480,
  parameter int V_FRONT      = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BACK       = 33,
  parameter int CLK_DIV      = 4,
  parameter bit HS_POL       = 1'b0,
  parameter bit VS_POL       = 1'b0,
  parameter int COLS         = 80,
  parameter int BLINK_FRAMES = 32
) (
  input logic        clk,
  input logic        rst,
  vga_text_if.master bus
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int XW = $clog2(H_TOTAL);
  localparam int YW = $clog2(V_TOTAL);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [FW-1:0] F_LAST   = FW'(BLINK_FRAMES - 1);
  localparam logic [XW-1:0] X_LAST   = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(V_TOTAL - 1);
  localparam logic [XW-1:0] X_VIS    = XW'(H_VISIBLE);
  localparam logic [YW-1:0] Y_VIS    = YW'(V_VISIBLE);
  localparam logic [XW-1:0] HS_FIRST = XW'(H_VISIBLE + H_FRONT);
  localparam logic [XW-1:0] HS_LAST  = XW'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [YW-1:0] VS_FIRST = YW'(V_VISIBLE + V_FRONT);
  localparam logic [YW-1:0] VS_LAST  = YW'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  // 5-bit DAC level for one colour component of a palette entry.
  function automatic logic [4:0] level5(input logic on, input logic intense);
    logic [4:0] lv;
    if (on) begin
      if (intense) lv = 5'd31;
      else         lv = 5'd21;
    end else begin
      if (intense) lv = 5'd10;
      else         lv = 5'd0;
    end
    return lv;
  endfunction

  // 6-bit DAC level for the green component of a palette entry.
  function automatic logic [5:0] level6(input logic on, input logic intense);
    logic [5:0] lv;
    if (on) begin
      if (intense) lv = 6'd63;
      else         lv = 6'd42;
    end else begin
      if (intense) lv = 6'd21;
      else         lv = 6'd0;
    end
    return lv;
  endfunction

  logic [DW-1:0] div_r;
  logic [XW-1:0] x_r;
  logic [YW-1:0] y_r;
  logic [FW-1:0] frame_r;
  logic          blink_r;
  logic          fs_r;
  logic          pe_s;
  logic          x_wrap_s;
  logic          y_wrap_s;

  assign pe_s     = (div_r == DIV_LAST);
  assign x_wrap_s = (x_r == X_LAST);
  assign y_wrap_s = (y_r == Y_LAST);

  // Pixel-clock-enable divider: pe on the last count of each period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       div_r <= '0;
    else if (pe_s) div_r <= '0;
    else           div_r <= div_r + DW'(1);
  end

  // Raster counters: x across the line, y steps when x wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_r <= '0;
      y_r <= '0;
    end else if (pe_s) begin
      if (x_wrap_s) begin
        x_r <= '0;
        if (y_wrap_s) y_r <= '0;
        else          y_r <= y_r + YW'(1);
      end else begin
        x_r <= x_r + XW'(1);
      end
    end
  end

  // Frame counter, blink phase and the undelayed frame_start pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_r <= '0;
      blink_r <= 1'b0;
      fs_r    <= 1'b0;
    end else begin
      fs_r <= pe_s && x_wrap_s && y_wrap_s;
      if (pe_s && x_wrap_s && y_wrap_s) begin
        if (frame_r == F_LAST) begin
          frame_r <= '0;
          blink_r <= ~blink_r;
        end else begin
          frame_r <= frame_r + FW'(1);
        end
      end
    end
  end

  // Stage 0 combinational: cell address, sync windows, display, cursor hit.
  logic [11:0] col_s;
  logic [11:0] row_s;
  logic [11:0] addr_s;
  logic        hs_act_s;
  logic        vs_act_s;
  logic        disp_s;
  logic        cur_hit_s;

  // Derive everything stage 0 registers from the current counters.
  always_comb begin
    col_s     = 12'(x_r >> 3);
    row_s     = 12'(y_r >> 4);
    addr_s    = row_s * 12'(COLS) + col_s;
    hs_act_s  = (x_r >= HS_FIRST) && (x_r <= HS_LAST);
    vs_act_s  = (y_r >= VS_FIRST) && (y_r <= VS_LAST);
    disp_s    = (x_r < X_VIS) && (y_r < Y_VIS);
    cur_hit_s = bus.cursor_en && (col_s == 12'(bus.cursor_col)) &&
                (row_s == 12'(bus.cursor_row));
  end

  logic [11:0] char_addr_r;
  logic        hs0_r, vs0_r, disp0_r, cur0_r;
  logic [2:0]  xl0_r;
  logic [3:0]  yl0_r;

  // Stage 0 registers: text RAM address plus the pixel's side-band.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      char_addr_r <= '0;
      hs0_r       <= 1'b0;
      vs0_r       <= 1'b0;
      disp0_r     <= 1'b0;
      cur0_r      <= 1'b0;
      xl0_r       <= '0;
      yl0_r       <= '0;
    end else if (pe_s) begin
      char_addr_r <= addr_s;
      hs0_r       <= hs_act_s;
      vs0_r       <= vs_act_s;
      disp0_r     <= disp_s;
      cur0_r      <= cur_hit_s;
      xl0_r       <= 3'(x_r);
      yl0_r       <= 4'(y_r);
    end
  end

  logic [11:0] font_addr_r;
  logic [7:0]  attr1_r;
  logic        hs1_r, vs1_r, disp1_r, cur1_r;
  logic [2:0]  xl1_r;
  logic [3:0]  yl1_r;

  // Stage 1 registers: sample the cell, form the font address, keep attrs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      font_addr_r <= '0;
      attr1_r     <= '0;
      hs1_r       <= 1'b0;
      vs1_r       <= 1'b0;
      disp1_r     <= 1'b0;
      cur1_r      <= 1'b0;
      xl1_r       <= '0;
      yl1_r       <= '0;
    end else if (pe_s) begin
      font_addr_r <= {bus.char_data[7:0], yl0_r};
      attr1_r     <= bus.char_data[15:8];
      hs1_r       <= hs0_r;
      vs1_r       <= vs0_r;
      disp1_r     <= disp0_r;
      cur1_r      <= cur0_r;
      xl1_r       <= xl0_r;
      yl1_r       <= yl0_r;
    end
  end

  logic [3:0] fg_s;
  logic [3:0] bg_s;
  logic [3:0] idx_s;
  logic       pix_s;
  logic       cur_on_s;
  logic [4:0] r_s, b_s;
  logic [5:0] g_s;

  // Stage 2 combinational: glyph bit, blink/cursor overrides, palette.
  always_comb begin
    bg_s     = {1'b0, attr1_r[6:4]};
    pix_s    = bus.font_data[3'd7 - xl1_r];
    cur_on_s = cur1_r && (yl1_r >= 4'd14) && !blink_r;
    if (attr1_r[7] && blink_r) fg_s = bg_s;
    else                       fg_s = attr1_r[3:0];
    if (pix_s || cur_on_s) idx_s = fg_s;
    else                   idx_s = bg_s;
    if (disp1_r) begin
      r_s = level5(idx_s[2], idx_s[3]);
      g_s = level6(idx_s[1], idx_s[3]);
      b_s = level5(idx_s[0], idx_s[3]);
    end else begin
      r_s = 5'd0;
      g_s = 6'd0;
      b_s = 5'd0;
    end
  end

  logic [4:0] r_r, b_r;
  logic [5:0] g_r;
  logic       hs_r, vs_r;

  // Stage 2 registers: colour and sync leave together, fully aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_r  <= 5'd0;
      g_r  <= 6'd0;
      b_r  <= 5'd0;
      hs_r <= ~HS_POL;
      vs_r <= ~VS_POL;
    end else if (pe_s) begin
      r_r  <= r_s;
      g_r  <= g_s;
      b_r  <= b_s;
      hs_r <= hs1_r ? HS_POL : ~HS_POL;
      vs_r <= vs1_r ? VS_POL : ~VS_POL;
    end
  end

  assign bus.char_addr   = char_addr_r;
  assign bus.font_addr   = font_addr_r;
  assign bus.r           = r_r;
  assign bus.g           = g_r;
  assign bus.b           = b_r;
  assign bus.hs          = hs_r;
  assign bus.vs          = vs_r;
  assign bus.frame_start = fs_r;

endmodule

// File: tb/tb_vga_text_core.sv
// Directed bench for vga_text_core: default 640x480 timing (A), a tiny
// 20x10 raster with inverted hsync (B) and a small raster for blink,
// cursor, addressing and vsync (C).
`timescale 1ns/1ps
module tb_vga_text_core;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_bc;
  int   checks = 0;
  int   errors = 0;
  int   pos = 0;

  always #5 clk = ~clk;

  vga_text_if a_if ();
  vga_text_if b_if ();
  vga_text_if c_if ();

  vga_text_core u_a (.clk(clk), .rst(rst_a), .bus(a_if));

  vga_text_core #(
    .CLK_DIV(1), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(4), .H_BACK(6),
    .V_VISIBLE(4), .V_FRONT(2), .V_SYNC(2), .V_BACK(2), .HS_POL(1'b1)
  ) u_b (.clk(clk), .rst(rst_bc), .bus(b_if));

  vga_text_core #(
    .CLK_DIV(1), .H_VISIBLE(48), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
    .V_VISIBLE(64), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .BLINK_FRAMES(2)
  ) u_c (.clk(clk), .rst(rst_bc), .bus(c_if));

  // C memories: cell 0 blinks (bg 1, fg F, code 41); all others code 42 bg 2.
  assign c_if.char_data = (c_if.char_addr == 12'd0) ? 16'h9F41 : 16'h2F42;
  assign c_if.font_data = (c_if.font_addr[11:4] == 8'h41) ? 8'hFF : 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  task automatic check_rgb(input string tag, input logic [4:0] r, input logic [5:0] g,
                           input logic [4:0] b, input int er, input int eg, input int eb);
    check({tag, ".r"}, 32'(r), 32'(er));
    check({tag, ".g"}, 32'(g), 32'(eg));
    check({tag, ".b"}, 32'(b), 32'(eb));
  endtask

  task automatic goto_pos(input int p);
    while (pos < p) begin
      @(negedge clk);
      pos++;
    end
  endtask

  task automatic wait_c_fs(input string tag);
    int n;
    n = 0;
    while (c_if.frame_start !== 1'b1 && n < 5000) begin
      @(negedge clk);
      pos++;
      n++;
    end
    check(tag, 32'(c_if.frame_start), 32'd1);
  endtask

  initial begin
    rst_a  = 1'b1;
    rst_bc = 1'b1;
    a_if.char_data  = 16'h0F41;
    a_if.font_data  = 8'h80;
    a_if.cursor_en  = 1'b0;
    a_if.cursor_col = 7'd0;
    a_if.cursor_row = 5'd0;
    b_if.char_data  = 16'h0000;
    b_if.font_data  = 8'h00;
    b_if.cursor_en  = 1'b0;
    b_if.cursor_col = 7'd0;
    b_if.cursor_row = 5'd0;
    c_if.cursor_en  = 1'b1;
    c_if.cursor_col = 7'd5;
    c_if.cursor_row = 5'd3;
    repeat (3) @(negedge clk);

    // Reset values
    check("a_rst_hs", 32'(a_if.hs), 32'd1);
    check("a_rst_vs", 32'(a_if.vs), 32'd1);
    check_rgb("a_rst_rgb", a_if.r, a_if.g, a_if.b, 0, 0, 0);
    check("a_rst_caddr", 32'(a_if.char_addr), 32'd0);
    check("a_rst_faddr", 32'(a_if.font_addr), 32'd0);
    check("a_rst_fs", 32'(a_if.frame_start), 32'd0);
    check("b_rst_hs", 32'(b_if.hs), 32'd0);
    check("c_rst_hs", 32'(c_if.hs), 32'd1);

    // ---- Instance A: default timing, CLK_DIV = 4 ----
    rst_a = 1'b0;
    pos = 0;
    goto_pos(9);    check("a_faddr_l0", 32'(a_if.font_addr), 32'h410);
    goto_pos(13);   check_rgb("a_px0", a_if.r, a_if.g, a_if.b, 31, 63, 31);
    goto_pos(17);   check_rgb("a_px1", a_if.r, a_if.g, a_if.b, 0, 0, 0);
    goto_pos(33);   check("a_caddr_x7", 32'(a_if.char_addr), 32'd0);
    goto_pos(37);   check("a_caddr_x8", 32'(a_if.char_addr), 32'd1);
    goto_pos(45);   check_rgb("a_px8", a_if.r, a_if.g, a_if.b, 31, 63, 31);
    goto_pos(2569); check_rgb("a_px639", a_if.r, a_if.g, a_if.b, 0, 0, 0);
    goto_pos(2635); check("a_hs_pre", 32'(a_if.hs), 32'd1);
    goto_pos(2636); check("a_hs_fall", 32'(a_if.hs), 32'd0);
    check("a_vs_line0", 32'(a_if.vs), 32'd1);
    goto_pos(2800); a_if.char_data = 16'h0441;
    goto_pos(3019); check("a_hs_last", 32'(a_if.hs), 32'd0);
    goto_pos(3020); check("a_hs_rise", 32'(a_if.hs), 32'd1);
    goto_pos(3213); check_rgb("a_fg4", a_if.r, a_if.g, a_if.b, 21, 0, 0);
    goto_pos(3217); check_rgb("a_bg0", a_if.r, a_if.g, a_if.b, 0, 0, 0);
    goto_pos(5835); check("a_hs_l1_pre", 32'(a_if.hs), 32'd1);
    goto_pos(5836); check("a_hs_period", 32'(a_if.hs), 32'd0);
    goto_pos(6000); a_if.char_data = 16'h0C41;
    goto_pos(6413); check_rgb("a_fgC", a_if.r, a_if.g, a_if.b, 31, 21, 10);
    goto_pos(9000); a_if.char_data = 16'h1041; a_if.font_data = 8'h00;
    goto_pos(9613); check_rgb("a_bg1", a_if.r, a_if.g, a_if.b, 0, 0, 21);
    goto_pos(9773); check("a_b_pre", 32'(a_if.b), 32'd21);
    check("a_caddr_pre", 32'(a_if.char_addr), 32'd5);
    check("a_faddr_pre", 32'(a_if.font_addr), 32'h413);
    // Mid-frame reset: outputs drop asynchronously, before any clock edge
    rst_a = 1'b1;
    #1;
    check_rgb("a_mid_rst_rgb", a_if.r, a_if.g, a_if.b, 0, 0, 0);
    check("a_mid_rst_caddr", 32'(a_if.char_addr), 32'd0);
    check("a_mid_rst_faddr", 32'(a_if.font_addr), 32'd0);
    check("a_mid_rst_hs", 32'(a_if.hs), 32'd1);

    // ---- Instances B and C released together ----
    @(negedge clk);
    rst_bc = 1'b0;
    pos = 0;
    goto_pos(12);  check("b_hs_pre", 32'(b_if.hs), 32'd0);
    goto_pos(13);  check("b_hs_on", 32'(b_if.hs), 32'd1);
    goto_pos(16);  check("b_hs_last", 32'(b_if.hs), 32'd1);
    goto_pos(17);  check("b_hs_off", 32'(b_if.hs), 32'd0);
    goto_pos(33);  check("b_hs_line1", 32'(b_if.hs), 32'd1);
    goto_pos(122); check("b_vs_pre", 32'(b_if.vs), 32'd1);
    goto_pos(123); check("b_vs_on", 32'(b_if.vs), 32'd0);
    goto_pos(199); check("b_fs_pre", 32'(b_if.frame_start), 32'd0);
    goto_pos(200); check("b_fs_on", 32'(b_if.frame_start), 32'd1);
    goto_pos(201); check("b_fs_off", 32'(b_if.frame_start), 32'd0);
    goto_pos(400); check("b_fs_period", 32'(b_if.frame_start), 32'd1);

    // C frame 1 (blink phase 0)
    wait_c_fs("c_fs1");
    check("c_fs1_pos", 32'(pos), 32'd3808);
    pos = 0;
    goto_pos(3);    check_rgb("c_blink_f1", c_if.r, c_if.g, c_if.b, 31, 63, 31);
    goto_pos(50);   check_rgb("c_vis_edge", c_if.r, c_if.g, c_if.b, 0, 42, 0);
    goto_pos(53);   check_rgb("c_blank", c_if.r, c_if.g, c_if.b, 0, 0, 0);
    goto_pos(905);  check("c_caddr_81", 32'(c_if.char_addr), 32'd81);
    goto_pos(3459); check_rgb("c_cur_l13", c_if.r, c_if.g, c_if.b, 0, 42, 0);
    goto_pos(3507); check_rgb("c_cur_col4", c_if.r, c_if.g, c_if.b, 0, 42, 0);
    goto_pos(3515); check_rgb("c_cur_l14", c_if.r, c_if.g, c_if.b, 31, 63, 31);
    goto_pos(3576); check("c_caddr_last", 32'(c_if.char_addr), 32'd245);
    goto_pos(3577); check("c_faddr_l15", 32'(c_if.font_addr), 32'h42F);
    goto_pos(3578); check_rgb("c_cur_l15", c_if.r, c_if.g, c_if.b, 31, 63, 31);

    // C frame 2 (blink phase 1)
    wait_c_fs("c_fs2");
    pos = 0;
    goto_pos(3);    check_rgb("c_blink_f2", c_if.r, c_if.g, c_if.b, 0, 0, 21);
    goto_pos(3515); check_rgb("c_cur_off", c_if.r, c_if.g, c_if.b, 0, 42, 0);
    goto_pos(3587); check("c_vs_pre", 32'(c_if.vs), 32'd1);
    goto_pos(3643); check("c_vs_on", 32'(c_if.vs), 32'd0);
    goto_pos(3754); check("c_vs_last", 32'(c_if.vs), 32'd0);
    goto_pos(3755); check("c_vs_end", 32'(c_if.vs), 32'd1);

    // C frame 3 still phase 1, frame 4 back to phase 0
    wait_c_fs("c_fs3");
    pos = 0;
    goto_pos(3);    check_rgb("c_blink_f3", c_if.r, c_if.g, c_if.b, 0, 0, 21);
    wait_c_fs("c_fs4");
    pos = 0;
    goto_pos(3);    check_rgb("c_blink_f4", c_if.r, c_if.g, c_if.b, 31, 63, 31);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
